// File: rtl/gamepad_move_arbiter.sv
// Converts dual gamepad button levels into one-at-a-time move commands over valid/ready.
// Define GAMEPAD_AUTOREPEAT_EN to build the hold-to-repeat counter.
module gamepad_move_arbiter #(
  parameter logic [23:0] REPEAT_DELAY  = 24'd6000000,
  parameter logic [23:0] REPEAT_PERIOD = 24'd2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] up,
  input  logic [1:0] down,
  input  logic [1:0] left,
  input  logic [1:0] right,
  input  logic [1:0] start,
  input  logic [1:0] is_present,
  output logic       move_valid,
  output logic [1:0] move_dir,
  output logic       move_player,
  input  logic       move_ready,
  output logic       restart
);

  // Handshake: a move transfers on a rising edge where move_valid & move_ready;
  // move_dir/move_player hold steady while move_valid is high and unaccepted.

  // Per-controller bit order: {start, right, left, down, up}
  logic [4:0] lvl [2];
  logic [4:0] prev [2];
  logic [4:0] press [2];
  logic [1:0] cand_valid;
  logic [1:0] cand_dir [2];
  logic       edge_en;
  logic       last_grant;
  logic       grant;
  logic       load;

`ifdef GAMEPAD_AUTOREPEAT_EN
  logic        rep_armed;
  logic        rep_player;
  logic [1:0]  rep_dir;
  logic [23:0] rep_count;
  logic        rep_periodic;
  logic        rep_held;
  logic        other_press;
  logic        rep_fire;
  logic [1:0]  cand_rep;
`endif

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      lvl[c] = {start[c], right[c], left[c], down[c], up[c]} & {5{is_present[c]}};
      // The first cycle out of reset only captures levels, so a button held
      // across reset does not register as a fresh press.
      press[c] = edge_en ? (lvl[c] & ~prev[c]) : 5'b0;
      cand_valid[c] = |press[c][3:0];
      if (press[c][0])      cand_dir[c] = 2'd0;
      else if (press[c][1]) cand_dir[c] = 2'd1;
      else if (press[c][2]) cand_dir[c] = 2'd2;
      else                  cand_dir[c] = 2'd3;
    end
`ifdef GAMEPAD_AUTOREPEAT_EN
    rep_held    = lvl[rep_player][rep_dir];
    other_press = |(press[rep_player][3:0] & ~(4'b0001 << rep_dir));
    rep_fire    = rep_armed & rep_held & ~other_press &
                  (rep_count == (rep_periodic ? REPEAT_PERIOD - 24'd1 : REPEAT_DELAY - 24'd1));
    cand_rep = 2'b00;
    if (rep_fire && !cand_valid[rep_player]) begin
      cand_valid[rep_player] = 1'b1;
      cand_dir[rep_player]   = rep_dir;
      cand_rep[rep_player]   = 1'b1;
    end
`endif
    grant = (&cand_valid) ? ~last_grant : cand_valid[1];
    load  = (|cand_valid) & (~move_valid | move_ready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev[0]     <= 5'b0;
      prev[1]     <= 5'b0;
      edge_en     <= 1'b0;
      restart     <= 1'b0;
      move_valid  <= 1'b0;
      move_dir    <= 2'd0;
      move_player <= 1'b0;
      last_grant  <= 1'b1;
    end else begin
      prev[0] <= lvl[0];
      prev[1] <= lvl[1];
      edge_en <= 1'b1;
      restart <= press[0][4] | press[1][4];
      if (load) begin
        move_valid  <= 1'b1;
        move_dir    <= cand_dir[grant];
        move_player <= grant;
        last_grant  <= grant;
      end else if (move_valid && move_ready) begin
        move_valid <= 1'b0;
      end
    end
  end

`ifdef GAMEPAD_AUTOREPEAT_EN
  // A load from a fresh press re-targets the tracker; a load of the repeat
  // itself leaves tracking alone so the period keeps running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_armed    <= 1'b0;
      rep_player   <= 1'b0;
      rep_dir      <= 2'd0;
      rep_count    <= 24'd0;
      rep_periodic <= 1'b0;
    end else if (load && !cand_rep[grant]) begin
      rep_armed    <= 1'b1;
      rep_player   <= grant;
      rep_dir      <= cand_dir[grant];
      rep_count    <= 24'd0;
      rep_periodic <= 1'b0;
    end else if (rep_armed && (!rep_held || other_press)) begin
      rep_armed    <= 1'b0;
      rep_count    <= 24'd0;
      rep_periodic <= 1'b0;
    end else if (rep_fire) begin
      rep_count    <= 24'd0;
      rep_periodic <= 1'b1;
    end else if (rep_armed && rep_count != 24'hFFFFFF) begin
      rep_count <= rep_count + 24'd1;
    end
  end
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

endmodule
